// File: rtl/axi_read_responder_if.sv
// AXI read-channel bundle (AR + R) between a read master and the memory-side responder.
// valid/ready: a transfer occurs on a posedge where both are high; a source holds its payload while valid && !ready.
interface axi_read_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [3:0]            ARID;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [3:0]            RID;
  logic                  RLAST;

  modport master (
    output ARVALID, ARADDR, ARLEN, ARID, RREADY,
    input  ARREADY, RVALID, RDATA, RID, RLAST
  );

  modport slave (
    input  ARVALID, ARADDR, ARLEN, ARID, RREADY,
    output ARREADY, RVALID, RDATA, RID, RLAST
  );
endinterface

// File: rtl/axi_read_responder.sv
// Memory-side AXI read slave: in-order request queue, fixed-latency access, burst
// return from an internal word array with a backdoor preload write port.
module axi_read_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int REQ_DEPTH      = 4,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_read_responder_if.slave       bus,
  input  logic                      wr_en,
  input  logic [MEM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic [1:0]                o_state
);
  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MEM_WORDS = 2 ** MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  // Request queue
  logic [MEM_ADDR_WIDTH-1:0] r_q_addr [REQ_DEPTH];
  logic [3:0]                r_q_len  [REQ_DEPTH];
  logic [3:0]                r_q_id   [REQ_DEPTH];
  logic [PTR_W-1:0]          r_wptr;
  logic [PTR_W-1:0]          r_rptr;
  logic [CNT_W-1:0]          r_count;
  logic                      w_arready;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_unused_addr_bits;

  // Burst engine
  state_t                    r_state;
  state_t                    w_state_n;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [MEM_ADDR_WIDTH-1:0] w_addr_n;
  logic [3:0]                r_rem;
  logic [3:0]                w_rem_n;
  logic [LAT_W-1:0]          r_lat;
  logic [LAT_W-1:0]          w_lat_n;
  logic [3:0]                r_rid;
  logic [3:0]                w_rid_n;
  logic                      r_rvalid;
  logic                      w_rvalid_n;
  logic                      r_rlast;
  logic                      w_rlast_n;
  logic                      w_load;
  logic [MEM_ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0]     r_rdata;

  logic [DATA_WIDTH-1:0]     r_mem [MEM_WORDS];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ARREADY comes straight from the registered count, so a pop while full
  // only frees a slot from the following cycle on.
  assign w_arready = (r_count != CNT_W'(REQ_DEPTH));
  assign w_push    = bus.ARVALID && w_arready;
  assign w_unused_addr_bits = ^{bus.ARADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], bus.ARADDR[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= bus.ARADDR[MEM_ADDR_WIDTH+1:2];
      r_q_len[r_wptr]  <= (bus.ARLEN == 4'd0) ? 4'd1 : bus.ARLEN;
      r_q_id[r_wptr]   <= bus.ARID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_rem    <= '0;
      r_lat    <= '0;
      r_rid    <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_addr   <= w_addr_n;
      r_rem    <= w_rem_n;
      r_lat    <= w_lat_n;
      r_rid    <= w_rid_n;
      r_rvalid <= w_rvalid_n;
      r_rlast  <= w_rlast_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_addr_n   = r_addr;
    w_rem_n    = r_rem;
    w_lat_n    = r_lat;
    w_rid_n    = r_rid;
    w_rvalid_n = r_rvalid;
    w_rlast_n  = r_rlast;
    w_pop      = 1'b0;
    w_load     = 1'b0;
    w_rd_addr  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop     = 1'b1;
          w_addr_n  = r_q_addr[r_rptr];
          w_rem_n   = r_q_len[r_rptr];
          w_rid_n   = r_q_id[r_rptr];
          w_lat_n   = LAT_W'(LATENCY - 1);
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat == '0) begin
          w_load     = 1'b1;
          w_rd_addr  = r_addr;
          w_rvalid_n = 1'b1;
          w_rlast_n  = (r_rem == 4'd1);
          w_state_n  = S_BURST;
        end else begin
          w_lat_n = r_lat - 1'b1;
        end
      end
      S_BURST: begin
        if (bus.RREADY) begin
          if (r_rlast) begin
            w_rvalid_n = 1'b0;
            w_rlast_n  = 1'b0;
            w_state_n  = S_IDLE;
          end else begin
            // Address wraps naturally at the top of the array.
            w_load    = 1'b1;
            w_rd_addr = r_addr + 1'b1;
            w_addr_n  = r_addr + 1'b1;
            w_rem_n   = r_rem - 1'b1;
            w_rlast_n = (r_rem == 4'd2);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Non-blocking write means a same-edge write to the word being loaded yields the old data.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_load) begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  assign bus.ARREADY = w_arready;
  assign bus.RVALID  = r_rvalid;
  assign bus.RDATA   = r_rdata;
  assign bus.RID     = r_rid;
  assign bus.RLAST   = r_rlast;
  assign o_state     = r_state;
endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: a scoreboard queue filled at request issue,
// drained by an independent monitor on every accepted read beat.
module tb_axi_read_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 10;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [MW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    o_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0]   model_mem [1024];
  logic [DW+4:0]   exp_q[$];

  axi_read_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_read_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MW), .REQ_DEPTH(4), .LATENCY(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .o_state (o_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks: called and return just after a posedge.
  task automatic mem_write(input logic [MW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic send_req(input logic [AW-1:0] addr, input logic [3:0] len, input logic [3:0] id);
    int n;
    int beats;
    logic [MW-1:0] w;
    bus.ARVALID = 1'b1;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARID    = id;
    n = 0;
    @(negedge clk);
    while (!bus.ARREADY && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ar_accept", bus.ARREADY, 1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    beats = (len == 4'd0) ? 1 : int'(len);
    w = addr[MW+1:2];
    for (int i = 0; i < beats; i++) begin
      exp_q.push_back({(i == beats - 1), id, model_mem[w]});
      w = w + 1'b1;
    end
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.RVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rvalid_seen", bus.RVALID, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [DW+4:0] e;
    if (!rst && bus.RVALID && bus.RREADY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data=%0h id=%0h with nothing expected", bus.RDATA, bus.RID);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", bus.RDATA, e[DW-1:0]);
        check("beat_id", bus.RID, e[DW+3:DW]);
        check("beat_last", bus.RLAST, e[DW+4]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int v;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    bus.ARVALID = 1'b0;
    bus.ARADDR = '0;
    bus.ARLEN = '0;
    bus.ARID = '0;
    bus.RREADY = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_rid", bus.RID, 0);
    check("rst_rlast", bus.RLAST, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_arready", bus.ARREADY, 1);
    check("idle_rvalid", bus.RVALID, 0);
    check("idle_rdata", bus.RDATA, 0);
    check("idle_state", o_state, 0);
    @(posedge clk); #1;

    // Preload
    for (int i = 0; i < 4; i++) mem_write(MW'(16 + i), 32'hA0 + 32'(i));
    for (int i = 0; i < 16; i++) mem_write(MW'(32 + i), 32'hB000 + 32'(i));
    mem_write(10'd1023, 32'hDEAD_03FF);
    mem_write(10'd0, 32'h1234_0000);

    // Basic 4-beat burst, latency and back-to-back beats
    bus.RREADY = 1'b1;
    send_req(32'h40, 4'd4, 4'd2);
    c0 = cyc;
    wait_rvalid();
    check("first_latency", cyc - c0, 3);
    v = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.RVALID) v++;
    end
    check("b2b_beats", v, 4);
    @(posedge clk); #1;
    wait_drain();

    // Stall on beat 1; a backdoor write during the stall must not disturb it
    send_req(32'h40, 4'd4, 4'd3);
    wait_rvalid();
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
    wr_en = 1'b1;
    wr_addr = 10'h11;
    wr_data = 32'h55;
    model_mem[10'h11] = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", bus.RVALID, 1);
      check("stall_data", bus.RDATA, 32'hA1);
      check("stall_last", bus.RLAST, 0);
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    bus.RREADY = 1'b1;
    wait_drain();

    // Five back-to-back requests with the read channel blocked
    bus.RREADY = 1'b0;
    for (int i = 0; i < 5; i++) send_req(32'h80 + 32'(8 * i), 4'd2, 4'(i));
    @(negedge clk);
    check("arready_full", bus.ARREADY, 0);
    @(posedge clk); #1;
    bus.RREADY = 1'b1;
    wait_drain();
    @(negedge clk);
    check("arready_after_drain", bus.ARREADY, 1);
    @(posedge clk); #1;

    // Wrap at array end, then ARLEN=0
    send_req(32'hFFC, 4'd2, 4'd5);
    wait_drain();
    send_req(32'h44, 4'd0, 4'd6);
    wait_drain();

    // Reset during beat 2 of a 4-beat burst with two requests queued
    bus.RREADY = 1'b0;
    send_req(32'h40, 4'd4, 4'd7);
    send_req(32'h48, 4'd2, 4'd8);
    send_req(32'h4C, 4'd1, 4'd9);
    wait_rvalid();
    @(posedge clk); #1;
    bus.RREADY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.RREADY = 1'b0;
    @(negedge clk);
    check("pre_rst_beat2", bus.RDATA, 32'hA2);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_rvalid", bus.RVALID, 0);
    check("rst_mid_rlast", bus.RLAST, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.RREADY = 1'b1;
    @(negedge clk);
    check("post_rst_arready", bus.ARREADY, 1);
    check("post_rst_state", o_state, 0);
    v = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.RVALID) v++;
    end
    check("no_stale_beats", v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
